// File: rtl/memory_stage_if.sv
// Memory stage request/response bundle.
// master drives the request, slave is the memory stage.
interface memory_stage_if;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [63:0] valP;
    logic [63:0] valM;
    logic        busy;
    logic        done;
    logic [1:0]  stat;

    modport master (
        output start, icode, valE, valA, valP,
        input  valM, busy, done, stat
    );

    modport slave (
        input  start, icode, valE, valA, valP,
        output valM, busy, done, stat
    );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 memory stage: byte-serial 64-bit load/store.
// Optional macro DMEM_ALIGN_CHECK_EN: unaligned accesses fault.
module memory_stage #(
    parameter int unsigned DMEM_BYTES = 1024
) (
    input logic           clk,
    input logic           rst_n,
    memory_stage_if.slave bus
);
    localparam int AW = $clog2(DMEM_BYTES);
    localparam logic [63:0] LIMIT = 64'(DMEM_BYTES - 8);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]    state;
    logic [2:0]    cnt;
    logic [AW-1:0] addr_q;
    logic [63:0]   wdata_q;
    logic [63:0]   rbuf;
    logic [63:0]   valm_q;
    logic [1:0]    stat_q;
    logic          wr_q;
    logic          halt_q;

    logic [7:0]    mem [DMEM_BYTES];

    logic          d_rd;
    logic          d_wr;
    logic          d_halt;
    logic          d_mis;
    logic          d_err;
    logic [63:0]   d_addr;
    logic [63:0]   d_wdata;
    logic [AW-1:0] baddr;
    logic [7:0]    rbyte;
    logic [7:0]    wbyte;

    // Decode the requested operation, its address and write data.
    always_comb begin
        d_rd    = 1'b0;
        d_wr    = 1'b0;
        d_halt  = 1'b0;
        d_addr  = bus.valE;
        d_wdata = bus.valA;
        unique case (1'b1)
            (bus.icode == 4'h4) || (bus.icode == 4'hA): d_wr = 1'b1;
            (bus.icode == 4'h8): begin
                d_wr    = 1'b1;
                d_wdata = bus.valP;
            end
            (bus.icode == 4'h5): d_rd = 1'b1;
            (bus.icode == 4'h9) || (bus.icode == 4'hB): begin
                d_rd   = 1'b1;
                d_addr = bus.valA;
            end
            (bus.icode == 4'h0): d_halt = 1'b1;
            default: ;
        endcase
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign d_mis = |d_addr[2:0];
`else
    assign d_mis = 1'b0;
`endif

    // Full 64-bit compare so huge addresses cannot wrap into range.
    assign d_err = (d_rd | d_wr) & ((d_addr > LIMIT) | d_mis);

    assign baddr = addr_q + AW'(cnt);
    assign rbyte = mem[baddr];
    assign wbyte = wdata_q[{cnt, 3'b000} +: 8];

    // Control FSM; reads assemble into rbuf so valM only moves on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 64'd0;
            rbuf    <= 64'd0;
            valm_q  <= 64'd0;
            stat_q  <= 2'b00;
            wr_q    <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        addr_q  <= d_addr[AW-1:0];
                        wdata_q <= d_wdata;
                        wr_q    <= d_wr;
                        cnt     <= 3'd0;
                        if (d_err) begin
                            state  <= S_DONE;
                            halt_q <= 1'b1;
                            stat_q <= 2'b10;
                        end else if (d_halt) begin
                            state  <= S_DONE;
                            halt_q <= 1'b1;
                            stat_q <= 2'b01;
                        end else if (d_rd | d_wr) begin
                            state  <= S_ACCESS;
                            halt_q <= 1'b0;
                        end else begin
                            state  <= S_DONE;
                            halt_q <= 1'b0;
                            stat_q <= 2'b00;
                        end
                    end
                end
                S_ACCESS: begin
                    cnt <= cnt + 3'd1;
                    if (!wr_q) begin
                        rbuf[{cnt, 3'b000} +: 8] <= rbyte;
                    end
                    if (cnt == 3'd7) begin
                        state  <= S_DONE;
                        stat_q <= 2'b00;
                        if (!wr_q) begin
                            valm_q <= {rbyte, rbuf[55:0]};
                        end
                    end
                end
                S_DONE: begin
                    state <= halt_q ? S_HALTED : S_IDLE;
                end
                default: begin
                    state <= S_HALTED;
                end
            endcase
        end
    end

    // Byte-wide data memory; deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && wr_q) begin
            mem[baddr] <= wbyte;
        end
    end

    assign bus.valM = valm_q;
    assign bus.busy = (state == S_ACCESS);
    assign bus.done = (state == S_DONE);
    assign bus.stat = stat_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage.
// Expected results are queued at issue and popped on done.
module tb_memory_stage;
    localparam int unsigned DB = 1024;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  lat;
        logic [1:0]  stat;
        logic [63:0] valm;
        logic        busy;
    } exp_t;

    logic clk;
    logic rst_n;
    memory_stage_if bus ();

    memory_stage #(.DMEM_BYTES(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks;
    int failures;
    exp_t sb[$];
    logic [7:0] mdl [DB];
    logic [63:0] cur_valm;
    logic [1:0] cur_stat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mdl_rd(input logic [63:0] a);
        logic [63:0] r;
        for (int k = 0; k < 8; k++)
            r[8*k +: 8] = mdl[(a + 64'(k)) % 64'(DB)];
        return r;
    endfunction

    task automatic issue(input logic [3:0] ic, input logic [63:0] e,
                         input logic [63:0] a, input logic [63:0] p,
                         input bit poke);
        exp_t x;
        exp_t y;
        bit rd, wr, hlt, err, sawbusy;
        logic [63:0] addr, data;
        int lat;
        rd   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        wr   = (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
        hlt  = (ic == 4'h0);
        addr = (ic == 4'h9 || ic == 4'hB) ? a : e;
        data = (ic == 4'h8) ? p : a;
        err  = (rd || wr) &&
               ((addr > 64'(DB - 8)) || (ALIGN && addr[2:0] != 3'd0));
        if (rd && !err) cur_valm = mdl_rd(addr);
        if (wr && !err)
            for (int k = 0; k < 8; k++)
                mdl[(addr + 64'(k)) % 64'(DB)] = data[8*k +: 8];
        cur_stat = err ? 2'b10 : (hlt ? 2'b01 : 2'b00);
        x.lat  = ((rd || wr) && !err) ? 8'd8 : 8'd0;
        x.stat = cur_stat;
        x.valm = cur_valm;
        x.busy = ((rd || wr) && !err);
        sb.push_back(x);

        @(negedge clk);
        bus.icode = ic;
        bus.valE  = e;
        bus.valA  = a;
        bus.valP  = p;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.icode = 4'h4;
        bus.valE  = {$urandom, $urandom};
        bus.valA  = {$urandom, $urandom};
        bus.valP  = {$urandom, $urandom};
        @(negedge clk);
        lat = 0;
        sawbusy = bus.busy;
        while (!bus.done && lat < 20) begin
            if (poke && lat == 3) begin
                bus.start = 1'b1;
                bus.icode = 4'h0;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            lat++;
            @(negedge clk);
            sawbusy |= bus.busy;
        end
        y = sb.pop_front();
        chk("latency", 64'(lat), 64'(y.lat));
        chk("stat", 64'(bus.stat), 64'(y.stat));
        chk("valM", bus.valM, y.valm);
        chk("busy_seen", 64'(sawbusy), 64'(y.busy));
        @(negedge clk);
        chk("done_pulse", 64'(bus.done), 64'd0);
    endtask

    task automatic ignore_start(input logic [3:0] ic);
        bit seen;
        @(negedge clk);
        bus.icode = ic;
        bus.valE  = 64'h10;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= bus.done | bus.busy;
        end
        chk("ignored", 64'(seen), 64'd0);
        chk("stat_held", 64'(bus.stat), 64'(cur_stat));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        cur_valm = 64'd0;
        cur_stat = 2'b00;
        chk("rst_valM", bus.valM, 64'd0);
        chk("rst_stat", 64'(bus.stat), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        checks   = 0;
        failures = 0;
        cur_valm = 64'd0;
        cur_stat = 2'b00;
        for (int i = 0; i < int'(DB); i++) mdl[i] = 8'h00;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.icode = 4'h1;
        bus.valE  = 64'd0;
        bus.valA  = 64'd0;
        bus.valP  = 64'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_reset();

        issue(4'h4, 64'h80, 64'h0, 64'h0, 1'b0);
        issue(4'h4, 64'h10, 64'h1122334455667788, 64'h0, 1'b0);
        issue(4'h5, 64'h10, 64'h0, 64'h0, 1'b0);
        chk("rd_0x10_const", bus.valM, 64'h1122334455667788);
        issue(4'h8, 64'h40, 64'h0, 64'hABCD, 1'b0);
        issue(4'h9, 64'h0, 64'h40, 64'h0, 1'b0);
        issue(4'hA, 64'h38, 64'h7, 64'h0, 1'b0);
        issue(4'hB, 64'h0, 64'h38, 64'h0, 1'b0);
        issue(4'h4, 64'd1016, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0);
        issue(4'h5, 64'd1016, 64'h0, 64'h0, 1'b0);
        issue(4'h6, 64'h10, 64'h0, 64'h0, 1'b0);
        issue(4'h4, 64'h20, 64'h0102030405060708, 64'h0, 1'b1);
        issue(4'h5, 64'h20, 64'h0, 64'h0, 1'b0);

        issue(4'h4, 64'h18, 64'h99AABBCCDDEEFF00, 64'h0, 1'b0);
        issue(4'h5, 64'h13, 64'h0, 64'h0, 1'b0);
        do_reset();

        issue(4'h4, 64'h80, 64'h0, 64'h0, 1'b0);
        @(negedge clk);
        bus.icode = 4'h4;
        bus.valE  = 64'h80;
        bus.valA  = 64'hFFFFFFFFFFFFFFFF;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        cur_valm = 64'd0;
        for (int k = 0; k < 4; k++) mdl[16'h80 + k] = 8'hFF;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_valM", bus.valM, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= bus.done;
        end
        chk("abort_nodone", 64'(seen), 64'd0);
        issue(4'h5, 64'h80, 64'h0, 64'h0, 1'b0);
        chk("abort_rd_const", bus.valM, 64'h00000000FFFFFFFF);

        issue(4'h5, 64'd1017, 64'h0, 64'h0, 1'b0);
        ignore_start(4'h6);
        do_reset();
        issue(4'h5, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h0, 1'b0);
        do_reset();
        issue(4'h0, 64'h0, 64'h0, 64'h0, 1'b0);
        ignore_start(4'h4);
        do_reset();
        issue(4'h6, 64'h0, 64'h0, 64'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
